// File: rtl/hash_control_unit.sv
// Sequencing controller for the byte-serial hash datapath: accepts message bytes,
// runs 8 message rounds per byte, FINAL_ROUNDS counter rounds, then holds the digest.
module hash_control_unit #(
    parameter int unsigned FINAL_ROUNDS = 8
) (
    input  logic       clock,
    input  logic       rstn,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       case_R_c_zero,
    input  logic       digest_ack,
    output logic       in_ready,
    output logic       dp_start,
    output logic       validate_input,
    output logic       validate_R_h,
    output logic       switch_operation,
    output logic [2:0] R_i,
    output logic       digest_valid,
    output logic       busy,
    output logic       error
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        ROUND     = 3'd2,
        FINAL     = 3'd3,
        DONE      = 3'd4,
        ERR       = 3'd5
    } state_t;

    localparam logic [2:0] LAST_FINAL = 3'(FINAL_ROUNDS - 1);

    state_t     r_state;
    logic [2:0] r_rnd;
    logic       r_last_q;

    logic       w_go;
    logic       w_start_ok;

    assign w_go       = rstn & ~abort;
    assign w_start_ok = start & ((r_state == IDLE) | (r_state == ERR));

    always_ff @(posedge clock) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_rnd    <= '0;
            r_last_q <= 1'b0;
        end else if (abort) begin
            r_state  <= IDLE;
            r_rnd    <= '0;
            r_last_q <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ERR: begin
                    if (start) begin
                        r_state  <= WAIT_BYTE;
                        r_rnd    <= '0;
                        r_last_q <= 1'b0;
                    end
                end
                WAIT_BYTE: begin
                    if (in_valid) begin
                        if (case_R_c_zero) begin
                            r_state  <= ROUND;
                            r_rnd    <= '0;
                            r_last_q <= in_last;
                        end else begin
                            r_state <= ERR;
                        end
                    end
                end
                ROUND: begin
                    if (r_rnd == 3'd7) begin
                        r_rnd   <= '0;
                        r_state <= r_last_q ? FINAL : WAIT_BYTE;
                    end else begin
                        r_rnd <= r_rnd + 3'd1;
                    end
                end
                FINAL: begin
                    if (r_rnd == LAST_FINAL) begin
                        r_rnd   <= '0;
                        r_state <= DONE;
                    end else begin
                        r_rnd <= r_rnd + 3'd1;
                    end
                end
                DONE: begin
                    if (digest_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_rnd   <= '0;
                end
            endcase
        end
    end

    // Strobes are decoded combinationally so a byte or start is honoured in the cycle it is presented.
    always_comb begin
        in_ready         = 1'b0;
        dp_start         = 1'b0;
        validate_input   = 1'b0;
        validate_R_h     = 1'b0;
        switch_operation = 1'b0;
        R_i              = '0;
        digest_valid     = 1'b0;
        busy             = (r_state != IDLE);
        error            = (r_state == ERR);
        dp_start         = w_go & w_start_ok;
        case (r_state)
            WAIT_BYTE: begin
                in_ready       = w_go;
                validate_input = w_go & in_valid & case_R_c_zero;
            end
            ROUND: begin
                validate_R_h = w_go;
                R_i          = r_rnd;
            end
            FINAL: begin
                validate_R_h     = w_go;
                switch_operation = 1'b1;
                R_i              = r_rnd;
            end
            DONE: begin
                digest_valid = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hash_control_unit.sv
// Directed bench for hash_control_unit: per-cycle expected output vectors are queued as
// stimulus is driven and compared at the following negedge.
module tb_hash_control_unit;

    logic clock;
    logic rstn, start, abort, in_valid, in_last, case_R_c_zero, digest_ack;

    logic       ir8, dps8, vi8, vr8, sw8, dv8, bz8, er8;
    logic [2:0] ri8;
    logic       ir3, dps3, vi3, vr3, sw3, dv3, bz3, er3;
    logic [2:0] ri3;

    hash_control_unit #(.FINAL_ROUNDS(8)) dut8 (
        .clock(clock), .rstn(rstn), .start(start), .abort(abort),
        .in_valid(in_valid), .in_last(in_last), .case_R_c_zero(case_R_c_zero),
        .digest_ack(digest_ack), .in_ready(ir8), .dp_start(dps8),
        .validate_input(vi8), .validate_R_h(vr8), .switch_operation(sw8),
        .R_i(ri8), .digest_valid(dv8), .busy(bz8), .error(er8)
    );

    hash_control_unit #(.FINAL_ROUNDS(3)) dut3 (
        .clock(clock), .rstn(rstn), .start(start), .abort(abort),
        .in_valid(in_valid), .in_last(in_last), .case_R_c_zero(case_R_c_zero),
        .digest_ack(digest_ack), .in_ready(ir3), .dp_start(dps3),
        .validate_input(vi3), .validate_R_h(vr3), .switch_operation(sw3),
        .R_i(ri3), .digest_valid(dv3), .busy(bz3), .error(er3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        bit          sel;
        logic [10:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int unsigned vectors = 0;
    int unsigned fails   = 0;

    // Packed as {in_ready, dp_start, validate_input, validate_R_h, switch_operation, R_i, digest_valid, busy, error}
    function automatic logic [10:0] ov(input bit ir, input bit dps, input bit vi, input bit vr,
                                       input bit sw, input logic [2:0] ri, input bit dv,
                                       input bit bz, input bit er);
        return {ir, dps, vi, vr, sw, ri, dv, bz, er};
    endfunction

    task automatic step(input bit s, input bit rn, input bit st, input bit ab, input bit iv,
                        input bit il, input bit cz, input bit ack, input bit chk,
                        input logic [10:0] e, input string tag);
        sb_item_t    item;
        logic [10:0] obs;
        rstn = rn; start = st; abort = ab; in_valid = iv; in_last = il;
        case_R_c_zero = cz; digest_ack = ack;
        if (chk) sb.push_back('{tag, s, e});
        @(negedge clock);
        if (chk) begin
            item = sb.pop_front();
            obs = item.sel ? {ir3, dps3, vi3, vr3, sw3, ri3, dv3, bz3, er3}
                           : {ir8, dps8, vi8, vr8, sw8, ri8, dv8, bz8, er8};
            vectors++;
            assert (obs === item.exp)
            else begin
                fails++;
                $error("FAIL %s: observed %b expected %b", item.tag, obs, item.exp);
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle_chk(input bit s, input string tag);
        step(s, 1, 0, 0, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd0,0,0,0), tag);
    endtask

    task automatic do_start(input bit s);
        step(s, 1, 1, 0, 0, 0, 1, 0, 1, ov(0,1,0,0,0,3'd0,0,0,0), "start");
    endtask

    task automatic byte_in(input bit s, input bit last);
        step(s, 1, 0, 0, 1, last, 1, 0, 1, ov(1,0,1,0,0,3'd0,0,1,0), "byte");
    endtask

    task automatic rounds(input bit s, input int unsigned n, input bit st);
        for (int k = 0; k < int'(n); k++)
            step(s, 1, st, 0, 0, 0, 1, 0, 1, ov(0,0,0,1,0,3'(k),0,1,0), "round");
    endtask

    task automatic finals(input bit s, input int unsigned n);
        for (int k = 0; k < int'(n); k++)
            step(s, 1, 0, 0, 0, 0, 1, 0, 1, ov(0,0,0,1,1,3'(k),0,1,0), "final");
    endtask

    task automatic do_reset;
        step(0, 0, 0, 0, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd0,0,0,0), "reset8");
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd0,0,0,0), "reset3");
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        case_R_c_zero = 1'b1; digest_ack = 1'b0;
        @(posedge clock);
        #1;
        do_reset();
        // start held while in reset must not leave the IDLE state
        step(0, 0, 1, 0, 0, 0, 1, 0, 0, '0, "");
        idle_chk(0, "idle_after_rst_start");

        // single-byte message, start ignored in ROUND and DONE
        do_start(0);
        byte_in(0, 1);
        rounds(0, 8, 1);
        finals(0, 8);
        step(0, 1, 0, 0, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd0,1,1,0), "done");
        step(0, 1, 1, 0, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd0,1,1,0), "done_start");
        step(0, 1, 0, 0, 0, 0, 1, 1, 1, ov(0,0,0,0,0,3'd0,1,1,0), "done_ack");
        idle_chk(0, "idle_after_ack");

        // three bytes with gaps 0, 3 and 1
        do_start(0);
        byte_in(0, 0);
        rounds(0, 8, 0);
        for (int g = 0; g < 3; g++)
            step(0, 1, 1, 0, 0, 0, 1, 0, 1, ov(1,0,0,0,0,3'd0,0,1,0), "gap");
        byte_in(0, 0);
        rounds(0, 8, 0);
        step(0, 1, 0, 0, 0, 0, 1, 0, 1, ov(1,0,0,0,0,3'd0,0,1,0), "gap");
        byte_in(0, 1);
        rounds(0, 8, 0);
        finals(0, 8);
        step(0, 1, 0, 0, 0, 0, 1, 1, 1, ov(0,0,0,0,0,3'd0,1,1,0), "done3_ack");
        idle_chk(0, "idle_after_3b");

        // counter saturated: error, then recovery via start
        do_start(0);
        step(0, 1, 0, 0, 1, 0, 0, 0, 1, ov(1,0,0,0,0,3'd0,0,1,0), "byte_sat");
        step(0, 1, 0, 0, 1, 1, 1, 0, 1, ov(0,0,0,0,0,3'd0,0,1,1), "err_hold");
        step(0, 1, 0, 0, 0, 0, 1, 1, 1, ov(0,0,0,0,0,3'd0,0,1,1), "err_hold2");
        step(0, 1, 1, 0, 0, 0, 1, 0, 1, ov(0,1,0,0,0,3'd0,0,1,1), "err_start");
        step(0, 1, 0, 0, 0, 0, 1, 0, 1, ov(1,0,0,0,0,3'd0,0,1,0), "err_recover");

        // abort at ROUND rnd=4
        byte_in(0, 1);
        rounds(0, 4, 0);
        step(0, 1, 0, 1, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd4,0,1,0), "abort_r4");
        idle_chk(0, "idle_after_abort");
        idle_chk(0, "idle_after_abort2");

        // reset during FINAL rnd=5
        do_start(0);
        byte_in(0, 1);
        rounds(0, 8, 0);
        finals(0, 5);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, '0, "");
        idle_chk(0, "idle_after_final_rst");

        // FINAL_ROUNDS=3 instance
        do_reset();
        do_start(1);
        byte_in(1, 1);
        rounds(1, 8, 0);
        finals(1, 3);
        step(1, 1, 0, 0, 0, 0, 1, 0, 1, ov(0,0,0,0,0,3'd0,1,1,0), "fr3_done");
        step(1, 1, 0, 0, 0, 0, 1, 1, 1, ov(0,0,0,0,0,3'd0,1,1,0), "fr3_ack");
        idle_chk(1, "fr3_idle");

        if (sb.size() != 0) begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
